// File: rtl/seq_detector_param_if.sv
// Signal bundle for seq_detector_param: stream, pattern configuration and match status.
// The master side drives the stream and configuration; the slave side is the detector.
interface seq_detector_param_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned LenW = $clog2(PAT_W + 1);

  logic             clear;
  logic             in_valid;
  logic             in;
  logic [PAT_W-1:0] pattern;
  logic [LenW-1:0]  pat_len;
  logic             overlap;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic [LenW-1:0]  fill;

  modport master (
    output clear, in_valid, in, pattern, pat_len, overlap,
    input  out, match_count, fill
  );

  modport slave (
    input  clear, in_valid, in, pattern, pat_len, overlap,
    output out, match_count, fill
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable pattern of 1..PAT_W bits,
// selectable overlap, a HOLD-cycle stretched match output and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned HOLD  = 2
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);
  localparam int unsigned LenW  = $clog2(PAT_W + 1);
  localparam int unsigned HoldW = $clog2(HOLD + 1);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift, pat_mask;
  logic [LenW-1:0]  fill_q, fill_d, fill_inc;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, cfg_ok, match;

  always_comb begin
    accept     = bus.in_valid & ~bus.clear;
    hist_shift = {hist_q[PAT_W-2:0], bus.in};
    fill_inc   = (fill_q == LenW'(PAT_W)) ? fill_q : fill_q + LenW'(1);
    cfg_ok     = (bus.pat_len != '0) && (bus.pat_len <= LenW'(PAT_W));
    // Only the low pat_len bits of history and pattern take part in the compare.
    pat_mask   = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      pat_mask[i] = (i < int'(bus.pat_len));
    end
    match = accept && cfg_ok && (fill_inc >= bus.pat_len) &&
            (((hist_shift ^ bus.pattern) & pat_mask) == '0);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    hold_d = (hold_q != '0) ? hold_q - HoldW'(1) : hold_q;
    if (bus.clear) begin
      hist_d = '0;
      fill_d = '0;
      hold_d = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (match) begin
        hold_d = HoldW'(HOLD);
        if (!bus.overlap) begin
          fill_d = '0;
        end
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.out         = (hold_q != '0);
  assign bus.match_count = cnt_q;
  assign bus.fill        = fill_q;
endmodule
